ras_ckpt: RTL and testbench

Parametrised return-address stack (RAS) for the CVA6 frontend branch predictor. It supersedes the fixed small-depth RAS that `RASDepth` selects, and adds circular overwrite-on-overflow, explicit over/underflow reporting, and misprediction repair through numbered checkpoints. It sits beside the BTB/BHT in the frontend and is driven by call/return decode and by the branch-unit resolve path.

---
 rtl/ras_ckpt.sv | 156 +++++++++++++++
 tb/tb_ras_ckpt.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ras_ckpt.sv
// Return-address stack with circular overwrite, over/underflow pulses and
// numbered checkpoints for misprediction repair.
// Optional feature macro: RAS_CKPT_EN (checkpoint storage and restore logic).
// Without it the checkpoint ports are accepted but ignored.
module ras_ckpt #(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned VLEN    = 32,
    parameter int unsigned NR_CKPT = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [VLEN-1:0]              push_addr_i,
    input  logic                         pop_i,
    output logic [VLEN-1:0]              top_o,
    output logic                         top_valid_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    input  logic                         ckpt_save_i,
    input  logic [$clog2(NR_CKPT)-1:0]   ckpt_save_id_i,
    input  logic                         ckpt_restore_i,
    input  logic [$clog2(NR_CKPT)-1:0]   ckpt_restore_id_i,
    output logic                         overflow_o,
    output logic                         underflow_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [VLEN-1:0] stack [DEPTH];
    logic [PW-1:0]   tos, tos_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic            ovf, ovf_nxt, unf, unf_nxt;
    logic            wr_en;
    logic [PW-1:0]   wr_idx;
    logic [VLEN-1:0] wr_data;

    // Selected restore slot, common to both builds.
    logic            restore_en;
    logic            slot_valid;
    logic [PW-1:0]   slot_tos;
    logic [CW-1:0]   slot_count;
    logic [VLEN-1:0] slot_top;

`ifdef RAS_CKPT_EN
    logic [NR_CKPT-1:0] ckpt_valid;
    logic [PW-1:0]      ckpt_tos   [NR_CKPT];
    logic [CW-1:0]      ckpt_count [NR_CKPT];
    logic [VLEN-1:0]    ckpt_top   [NR_CKPT];

    assign restore_en = ckpt_restore_i;
    assign slot_valid = ckpt_valid[ckpt_restore_id_i];
    assign slot_tos   = ckpt_tos[ckpt_restore_id_i];
    assign slot_count = ckpt_count[ckpt_restore_id_i];
    assign slot_top   = ckpt_top[ckpt_restore_id_i];

    // Checkpoint slots: snapshot pre-update state; flush/reset invalidate all.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            ckpt_valid <= '0;
        end else if (ckpt_save_i && !ckpt_restore_i) begin
            ckpt_valid[ckpt_save_id_i] <= 1'b1;
            ckpt_tos[ckpt_save_id_i]   <= tos;
            ckpt_count[ckpt_save_id_i] <= count;
            ckpt_top[ckpt_save_id_i]   <= stack[tos];
        end
    end
`else
    assign restore_en = 1'b0;
    assign slot_valid = 1'b0;
    assign slot_tos   = '0;
    assign slot_count = '0;
    assign slot_top   = '0;

    logic unused_ckpt;
    assign unused_ckpt = ^{ckpt_save_i, ckpt_save_id_i, ckpt_restore_i, ckpt_restore_id_i};
`endif

    // Next-state decode in priority order: flush > restore > push/pop.
    always_comb begin
        tos_nxt   = tos;
        count_nxt = count;
        ovf_nxt   = 1'b0;
        unf_nxt   = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = tos;
        wr_data   = push_addr_i;
        if (flush_i) begin
            tos_nxt   = '0;
            count_nxt = '0;
        end else if (restore_en) begin
            if (slot_valid) begin
                tos_nxt   = slot_tos;
                count_nxt = slot_count;
                // Undo a wrong-path push that clobbered the saved top.
                wr_en     = 1'b1;
                wr_idx    = slot_tos;
                wr_data   = slot_top;
            end else begin
                tos_nxt   = '0;
                count_nxt = '0;
            end
        end else if (push_i && pop_i) begin
            wr_en = 1'b1;
            if (count == '0) begin
                count_nxt = CW'(1);
            end
        end else if (push_i) begin
            tos_nxt = tos + PW'(1);
            wr_en   = 1'b1;
            wr_idx  = tos + PW'(1);
            if (count == FULL) begin
                ovf_nxt = 1'b1;
            end else begin
                count_nxt = count + CW'(1);
            end
        end else if (pop_i) begin
            if (count != '0) begin
                tos_nxt   = tos - PW'(1);
                count_nxt = count - CW'(1);
            end else begin
                unf_nxt = 1'b1;
            end
        end
    end

    // Pointer, occupancy and event pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tos   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            tos   <= tos_nxt;
            count <= count_nxt;
            ovf   <= ovf_nxt;
            unf   <= unf_nxt;
        end
    end

    // Entry storage; contents are not reset, only guarded from writes during reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_en) begin
            stack[wr_idx] <= wr_data;
        end
    end

    assign top_o       = (count != '0) ? stack[tos] : '0;
    assign top_valid_o = (count != '0);
    assign count_o     = count;
    assign overflow_o  = ovf;
    assign underflow_o = unf;

endmodule

// File: tb/tb_ras_ckpt.sv
// Self-checking bench for ras_ckpt (DEPTH=2, VLEN=32, NR_CKPT=2): table-driven
// vectors, hand-written checkpoint/priority/reset sequences, then random traffic
// compared against a behavioural model. Honours RAS_CKPT_EN like the design.
module tb_ras_ckpt;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst_i, flush_i, push_i, pop_i;
    logic [31:0] push_addr_i;
    logic [31:0] top_o;
    logic        top_valid_o;
    logic [1:0]  count_o;
    logic        ckpt_save_i, ckpt_restore_i;
    logic [0:0]  ckpt_save_id_i, ckpt_restore_id_i;
    logic        overflow_o, underflow_o;

    int checks = 0;
    int errors = 0;

    ras_ckpt #(.DEPTH(2), .VLEN(32), .NR_CKPT(2)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .push_i           (push_i),
        .push_addr_i      (push_addr_i),
        .pop_i            (pop_i),
        .top_o            (top_o),
        .top_valid_o      (top_valid_o),
        .count_o          (count_o),
        .ckpt_save_i      (ckpt_save_i),
        .ckpt_save_id_i   (ckpt_save_id_i),
        .ckpt_restore_i   (ckpt_restore_i),
        .ckpt_restore_id_i(ckpt_restore_id_i),
        .overflow_o       (overflow_o),
        .underflow_o      (underflow_o)
    );

    always #5 clk = ~clk;

    // Behavioural model: circular buffer of DEPTH entries plus checkpoint slots.
`ifdef RAS_CKPT_EN
    localparam bit CKPT = 1'b1;
`else
    localparam bit CKPT = 1'b0;
`endif
    logic [31:0] m_mem [D];
    int          m_tos, m_cnt;
    logic        m_ovf, m_unf;
    logic        ck_valid [2];
    int          ck_tos [2];
    int          ck_cnt [2];
    logic [31:0] ck_top [2];

    function automatic void model_apply(logic rst, logic push, logic pop, logic [31:0] addr,
                                        logic flush, logic save, int sid,
                                        logic restore, int rid);
        int          p_tos = m_tos;
        int          p_cnt = m_cnt;
        logic [31:0] p_top = m_mem[m_tos];
        m_ovf = 1'b0;
        m_unf = 1'b0;
        if (rst) begin
            m_tos = 0;
            m_cnt = 0;
            ck_valid[0] = 1'b0;
            ck_valid[1] = 1'b0;
            return;
        end
        if (flush) begin
            m_tos = 0;
            m_cnt = 0;
            ck_valid[0] = 1'b0;
            ck_valid[1] = 1'b0;
        end else if (CKPT && restore) begin
            if (ck_valid[rid]) begin
                m_tos = ck_tos[rid];
                m_cnt = ck_cnt[rid];
                m_mem[m_tos] = ck_top[rid];
            end else begin
                m_tos = 0;
                m_cnt = 0;
            end
        end else if (push && pop) begin
            m_mem[m_tos] = addr;
            if (m_cnt == 0) m_cnt = 1;
        end else if (push) begin
            m_tos = (m_tos + 1) % D;
            m_mem[m_tos] = addr;
            if (m_cnt == D) m_ovf = 1'b1;
            else m_cnt = m_cnt + 1;
        end else if (pop) begin
            if (m_cnt > 0) begin
                m_tos = (m_tos + D - 1) % D;
                m_cnt = m_cnt - 1;
            end else begin
                m_unf = 1'b1;
            end
        end
        if (CKPT && save && !flush && !restore) begin
            ck_valid[sid] = 1'b1;
            ck_tos[sid]   = p_tos;
            ck_cnt[sid]   = p_cnt;
            ck_top[sid]   = p_top;
        end
    endfunction

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void check_model(string tag);
        check({tag, " top"}, top_o, (m_cnt > 0) ? m_mem[m_tos] : 32'h0);
        check({tag, " valid"}, 32'(top_valid_o), 32'(m_cnt > 0));
        check({tag, " count"}, 32'(count_o), 32'(m_cnt));
        check({tag, " ovf"}, 32'(overflow_o), 32'(m_ovf));
        check({tag, " unf"}, 32'(underflow_o), 32'(m_unf));
    endfunction

    // One clock: drive inputs, clock, advance model, settle for sampling.
    task automatic step(logic rst, logic push, logic pop, logic [31:0] addr, logic flush,
                        logic save, int sid, logic restore, int rid);
        rst_i = rst;
        push_i = push;
        pop_i = pop;
        push_addr_i = addr;
        flush_i = flush;
        ckpt_save_i = save;
        ckpt_save_id_i = 1'(sid);
        ckpt_restore_i = restore;
        ckpt_restore_id_i = 1'(rid);
        @(posedge clk);
        model_apply(rst, push, pop, addr, flush, save, sid, restore, rid);
        #1;
    endtask

    task automatic expect_out(string tag, logic [31:0] t, int c, logic o, logic u);
        check({tag, " top"}, top_o, t);
        check({tag, " count"}, 32'(count_o), 32'(c));
        check({tag, " valid"}, 32'(top_valid_o), 32'(c > 0));
        check({tag, " ovf"}, 32'(overflow_o), 32'(o));
        check({tag, " unf"}, 32'(underflow_o), 32'(u));
    endtask

    typedef struct {
        logic        push;
        logic        pop;
        logic [31:0] addr;
        logic [31:0] e_top;
        int          e_cnt;
        logic        e_ovf;
        logic        e_unf;
    } vec_t;

    vec_t tbl [14];

    initial begin
        for (int i = 0; i < D; i++) m_mem[i] = '0;
        tbl[0]  = '{1'b0, 1'b1, 32'h0,   32'h0,   0, 1'b0, 1'b1}; // pop on empty
        tbl[1]  = '{1'b0, 1'b0, 32'h0,   32'h0,   0, 1'b0, 1'b0}; // pulse is single
        tbl[2]  = '{1'b1, 1'b0, 32'h100, 32'h100, 1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 32'h200, 32'h200, 2, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 32'h300, 32'h300, 2, 1'b1, 1'b0}; // overwrites 0x100
        tbl[5]  = '{1'b0, 1'b0, 32'h0,   32'h300, 2, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 32'h0,   32'h200, 1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 32'h0,   32'h0,   0, 1'b0, 1'b0}; // 0x100 lost
        tbl[8]  = '{1'b1, 1'b0, 32'h40,  32'h40,  1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 32'h80,  32'h80,  1, 1'b0, 1'b0}; // call-through-return
        tbl[10] = '{1'b0, 1'b1, 32'h0,   32'h0,   0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 32'h55,  32'h55,  1, 1'b0, 1'b0}; // on empty: count->1
        tbl[12] = '{1'b0, 1'b1, 32'h0,   32'h0,   0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 32'h0,   32'h0,   0, 1'b0, 1'b1};

        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("reset", 32'h0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 14; i++) begin
            step(0, tbl[i].push, tbl[i].pop, tbl[i].addr, 0, 0, 0, 0, 0);
            expect_out($sformatf("vec%0d", i), tbl[i].e_top, tbl[i].e_cnt,
                       tbl[i].e_ovf, tbl[i].e_unf);
        end

        // Reset while an overflowing push is in flight: no pulse survives.
        step(0, 1, 0, 32'h1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 32'h2, 0, 0, 0, 0, 0);
        step(1, 1, 0, 32'h3, 0, 0, 0, 0, 0);
        expect_out("rst_mid", 32'h0, 0, 1'b0, 1'b0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("rst_mid_after", 32'h0, 0, 1'b0, 1'b0);

        // Checkpoint repair after a wrong-path overflow.
        step(0, 1, 0, 32'h500, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 0, 0);
        step(0, 1, 0, 32'h600, 0, 0, 0, 0, 0);
        step(0, 1, 0, 32'h700, 0, 0, 0, 0, 0);
        expect_out("repair_pre", 32'h700, 2, 1'b1, 1'b0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);
        if (CKPT) expect_out("repair", 32'h500, 1, 1'b0, 1'b0);
        else expect_out("repair_off", 32'h700, 2, 1'b0, 1'b0);

        // Flush invalidates checkpoints.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 32'hA, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 32'hB, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        if (CKPT) expect_out("flush_inv", 32'h0, 0, 1'b0, 1'b0);
        else expect_out("flush_inv_off", 32'hB, 1, 1'b0, 1'b0);

        // Flush beats push and save in the same cycle.
        step(0, 1, 0, 32'h11, 0, 0, 0, 0, 0);
        step(0, 1, 0, 32'h900, 1, 1, 0, 0, 0);
        expect_out("prio_flush", 32'h0, 0, 1'b0, 1'b0);
        step(0, 1, 0, 32'h22, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        if (CKPT) expect_out("prio_restore", 32'h0, 0, 1'b0, 1'b0);
        else expect_out("prio_restore_off", 32'h22, 1, 1'b0, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) == 0), int'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), int'($urandom_range(0, 1)));
            check_model($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
